// File: rtl/sram_qpi_reader.sv
// sram_qpi_reader
// Streams captured samples back out of an external quad-SPI SRAM that is
// already in SQI mode. A start issues READ_CMD, a 24-bit address and
// DUMMY_CLOCKS dummy clocks, then packs the returned nibbles into bytes and
// delivers them on a valid/ready stream.
//
// Ports
//   clock, reset_n        system clock, synchronous active-low reset
//   start                 one-cycle request, honoured only in IDLE
//   start_addr, length    first byte address / byte count, latched on start
//   busy, done            transfer in progress / final byte accepted (pulse)
//   data_out, data_valid  byte stream out (first nibble received is [7:4])
//   data_ready            consumer accept
//   sram_cs               active-low chip select
//   sram_clock            SRAM clock, idle low
//   sram_sio_tdo/_tdi/_oe SIO[3:0] drive value, sampled value, drive enable
module sram_qpi_reader #(
   parameter logic [7:0] READ_CMD     = 8'h03,
   parameter int         DUMMY_CLOCKS = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [23:0] start_addr,
   input  logic [15:0] length,
   output logic        busy,
   output logic        done,
   output logic [7:0]  data_out,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        sram_cs,
   output logic        sram_clock,
   output logic [3:0]  sram_sio_tdo,
   input  logic [3:0]  sram_sio_tdi,
   output logic [3:0]  sram_sio_oe
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, FINISH} state_t;

   localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CLOCKS - 1);

   state_t      state;
   logic        phase;       // 0: sram_clock low half, 1: high half
   logic        nib_sel;     // 0: next sample is the high nibble of a byte
   logic [3:0]  cnt;         // SRAM clock index inside CMD/ADDR/DUMMY
   logic [23:0] addr;
   logic [15:0] bytes_left;
   logic [3:0]  hi_nib;
   logic        zero_done;   // done pulse for a zero-length request

   logic hs;
   logic stall;

   assign hs    = data_valid && data_ready;
   // A byte may only start clocking in once the output register is free or
   // being emptied this cycle; otherwise hold the SRAM clock low.
   assign stall = !nib_sel && data_valid && !data_ready;

   assign busy  = (state != IDLE);
   // done must coincide with the handshake of the final byte, so it is
   // decoded from the handshake rather than registered.
   assign done  = zero_done || (state == FINISH && hs);

   function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [3:0] i);
      case (i)
         4'd0:    return a[23:20];
         4'd1:    return a[19:16];
         4'd2:    return a[15:12];
         4'd3:    return a[11:8];
         4'd4:    return a[7:4];
         4'd5:    return a[3:0];
         default: return 4'h0;
      endcase
   endfunction

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= IDLE;
         phase        <= 1'b0;
         nib_sel      <= 1'b0;
         cnt          <= '0;
         addr         <= '0;
         bytes_left   <= '0;
         hi_nib       <= '0;
         zero_done    <= 1'b0;
         data_out     <= '0;
         data_valid   <= 1'b0;
         sram_cs      <= 1'b1;
         sram_clock   <= 1'b0;
         sram_sio_tdo <= '0;
         sram_sio_oe  <= '0;
      end else begin
         zero_done <= 1'b0;
         if (hs) data_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     zero_done <= 1'b1;
                  end else begin
                     addr         <= start_addr;
                     bytes_left   <= length;
                     cnt          <= '0;
                     phase        <= 1'b0;
                     sram_cs      <= 1'b0;
                     sram_clock   <= 1'b0;
                     sram_sio_oe  <= 4'hF;
                     sram_sio_tdo <= READ_CMD[7:4];
                     state        <= CMD;
                  end
               end
            end

            CMD, ADDR, DUMMY: begin
               if (!phase) begin
                  phase      <= 1'b1;
                  sram_clock <= 1'b1;
               end else begin
                  // End of an SRAM clock: next nibble goes out with phase 0.
                  phase      <= 1'b0;
                  sram_clock <= 1'b0;
                  cnt        <= cnt + 4'd1;
                  case (state)
                     CMD: begin
                        if (cnt == 4'd0) begin
                           sram_sio_tdo <= READ_CMD[3:0];
                        end else begin
                           cnt          <= '0;
                           sram_sio_tdo <= addr_nib(addr, 4'd0);
                           state        <= ADDR;
                        end
                     end
                     ADDR: begin
                        if (cnt != 4'd5) begin
                           sram_sio_tdo <= addr_nib(addr, cnt + 4'd1);
                        end else begin
                           cnt          <= '0;
                           nib_sel      <= 1'b0;
                           sram_sio_oe  <= 4'h0;
                           sram_sio_tdo <= 4'h0;
                           state        <= (DUMMY_CLOCKS == 0) ? READ : DUMMY;
                        end
                     end
                     DUMMY: begin
                        if (cnt == DUMMY_LAST) begin
                           nib_sel <= 1'b0;
                           state   <= READ;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            READ: begin
               if (!phase) begin
                  if (!stall) begin
                     phase      <= 1'b1;
                     sram_clock <= 1'b1;
                  end
               end else begin
                  phase      <= 1'b0;
                  sram_clock <= 1'b0;
                  if (!nib_sel) begin
                     hi_nib  <= sram_sio_tdi;
                     nib_sel <= 1'b1;
                  end else begin
                     nib_sel    <= 1'b0;
                     data_out   <= {hi_nib, sram_sio_tdi};
                     data_valid <= 1'b1;
                     bytes_left <= bytes_left - 16'd1;
                     if (bytes_left == 16'd1) begin
                        // Last nibble in: release the SRAM, then wait for
                        // the consumer to take the final byte.
                        sram_cs <= 1'b1;
                        state   <= FINISH;
                     end
                  end
               end
            end

            FINISH: begin
               if (hs) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_qpi_reader.sv
module tb_sram_qpi_reader;

   localparam logic [7:0] CMD   = 8'h03;
   localparam int         DUMMY = 2;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [23:0] start_addr;
   logic [15:0] length;
   logic        busy;
   logic        done;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;
   logic        sram_cs;
   logic        sram_clock;
   logic [3:0]  sram_sio_tdo;
   logic [3:0]  sram_sio_tdi;
   logic [3:0]  sram_sio_oe;

   sram_qpi_reader #(.READ_CMD(CMD), .DUMMY_CLOCKS(DUMMY)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
      .length(length), .busy(busy), .done(done), .data_out(data_out),
      .data_valid(data_valid), .data_ready(data_ready), .sram_cs(sram_cs),
      .sram_clock(sram_clock), .sram_sio_tdo(sram_sio_tdo),
      .sram_sio_tdi(sram_sio_tdi), .sram_sio_oe(sram_sio_oe)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- SRAM model ----------------
   logic [7:0]  model_bytes [0:15];
   logic [5:0]  m_nib      = '0;
   logic [7:0]  m_sclk     = '0;
   logic [31:0] m_sh       = '0;
   int          m_sclk_tot = 0;
   int          m_cmds     = 0;
   int          m_oe_err   = 0;
   logic        m_prev_cs  = 1'b1;
   logic        m_bad;

   assign sram_sio_tdi = m_nib[0] ? model_bytes[m_nib[4:1]][3:0]
                                  : model_bytes[m_nib[4:1]][7:4];

   // Bad pin state: driving a value with oe off, or wrong oe for the
   // command/address vs. dummy/data part of the transaction.
   assign m_bad = (sram_sio_oe == 4'h0 && sram_sio_tdo != 4'h0) ||
                  (!sram_cs && sram_clock && m_sclk <  8'd8 && sram_sio_oe != 4'hF) ||
                  (!sram_cs && sram_clock && m_sclk >= 8'd8 && sram_sio_oe != 4'h0);

   always @(posedge clock) begin
      m_prev_cs <= sram_cs;
      if (m_prev_cs && !sram_cs) m_cmds <= m_cmds + 1;
      if (m_bad) m_oe_err <= m_oe_err + 1;
      if (sram_cs) begin
         m_sclk <= '0;
         m_nib  <= '0;
      end else if (sram_clock) begin
         m_sclk     <= m_sclk + 8'd1;
         m_sclk_tot <= m_sclk_tot + 1;
         if (m_sclk < 8'd8) m_sh <= {m_sh[27:0], sram_sio_tdo};
         if (m_sclk >= 8'(8 + DUMMY)) m_nib <= m_nib + 6'd1;
      end
   end

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] sb [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [23:0] addr;
      logic [15:0] len;
      logic [7:0]  seed;      // byte i returned by the SRAM = seed + i
      int          stall_lo;  // data_ready low in cycles [stall_lo, stall_hi]
      int          stall_hi;
      int          dup_rel;   // cycle of an extra start pulse while busy (0 = none)
      int          exp_done;  // cycle of done, also cycle CS rises
   } vec_t;

   vec_t tbl [0:3];

   task automatic run_xfer(input vec_t v);
      int   rel, done_rel, cs_rise, win_bad, t_sclk, t_cmd, t_oe;
      logic prev_valid, prev_cs;
      int   vr [$];
      logic [7:0] b;
      for (int i = 0; i < 16; i++) model_bytes[i] = v.seed + 8'(i);
      for (int i = 0; i < int'(v.len); i++) sb.push_back(v.seed + 8'(i));
      t_sclk = m_sclk_tot; t_cmd = m_cmds; t_oe = m_oe_err;
      done_rel = -1; cs_rise = -1; win_bad = 0; prev_valid = 1'b0; prev_cs = 1'b1; rel = 0;
      @(negedge clock);
      start_addr = v.addr; length = v.len; start = 1'b1; data_ready = 1'b1;
      while (done_rel < 0 && rel < 400) begin
         @(negedge clock);
         rel++;
         if (rel == 1) start = 1'b0;
         if (v.dup_rel != 0 && rel == v.dup_rel) begin
            start = 1'b1; start_addr = 24'hFFFFF0; length = 16'd9;
         end
         if (v.dup_rel != 0 && rel == v.dup_rel + 1) start = 1'b0;
         data_ready = !(rel >= v.stall_lo && rel <= v.stall_hi);
         #1;
         if (rel == 1) begin
            chk("cs_low_c1", 32'(sram_cs), 32'd0);
            chk("busy_c1",   32'(busy), 32'd1);
            chk("oe_cmd",    32'(sram_sio_oe), 32'hF);
            chk("tdo_cmd_hi", 32'(sram_sio_tdo), 32'(CMD[7:4]));
         end
         if (rel == 3) chk("tdo_cmd_lo", 32'(sram_sio_tdo), 32'(CMD[3:0]));
         if (rel == 21) begin
            chk("oe_read", 32'(sram_sio_oe), 32'd0);
            chk("cs_read", 32'(sram_cs), 32'd0);
         end
         if (data_valid && !prev_valid) vr.push_back(rel);
         if (sram_cs && !prev_cs) cs_rise = rel;
         if (rel >= v.stall_lo && rel <= v.stall_hi && (sram_clock || sram_cs)) win_bad++;
         if (data_valid && data_ready) begin
            if (sb.size() == 0) chk("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
            else begin
               b = sb.pop_front();
               chk("data_out", 32'(data_out), 32'(b));
            end
         end
         if (done) done_rel = rel;
         prev_valid = data_valid;
         prev_cs    = sram_cs;
      end
      @(negedge clock); #1;
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_cycle", 32'(done_rel), 32'(v.exp_done));
      chk("cs_rise_cycle", 32'(cs_rise), 32'(v.exp_done));
      chk("byte_count", 32'(vr.size()), 32'(v.len));
      if (vr.size() > 0) chk("first_valid", 32'(vr[0]), 32'd25);
      if (v.stall_lo < 0)
         for (int i = 0; i < vr.size(); i++) chk("valid_cycle", 32'(vr[i]), 32'(25 + 4 * i));
      else
         chk("stall_window", 32'(win_bad), 32'd0);
      chk("sram_clocks", 32'(m_sclk_tot - t_sclk), 32'(8 + DUMMY + 2 * int'(v.len)));
      chk("cmd_count", 32'(m_cmds - t_cmd), 32'd1);
      chk("cmd_addr", m_sh, {CMD, v.addr});
      chk("pin_errors", 32'(m_oe_err - t_oe), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int t_sclk, t_cmd;
      tbl[0] = '{24'h012345, 16'd1, 8'hA5, -1, -1, 0, 25};
      tbl[1] = '{24'h000100, 16'd4, 8'h00, -1, -1, 0, 37};
      tbl[2] = '{24'h3C0F00, 16'd3, 8'h3C, 25, 40, 0, 49};
      tbl[3] = '{24'h00ABCD, 16'd2, 8'h71, -1, -1, 8, 29};
      for (int i = 0; i < 16; i++) model_bytes[i] = 8'h00;

      reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; data_ready = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_cs",    32'(sram_cs), 32'd1);
      chk("rst_sclk",  32'(sram_clock), 32'd0);
      chk("rst_tdo",   32'(sram_sio_tdo), 32'd0);
      chk("rst_oe",    32'(sram_sio_oe), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_data",  32'(data_out), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) run_xfer(tbl[i]);

      // zero-length request: done next cycle, no SRAM activity
      t_sclk = m_sclk_tot; t_cmd = m_cmds;
      @(negedge clock);
      start_addr = 24'h000040; length = 16'd0; start = 1'b1;
      #1 chk("zl_done_c0", 32'(done), 32'd0);
      @(negedge clock); start = 1'b0; #1;
      chk("zl_done_c1", 32'(done), 32'd1);
      chk("zl_cs_c1",   32'(sram_cs), 32'd1);
      chk("zl_busy_c1", 32'(busy), 32'd0);
      @(negedge clock); #1;
      chk("zl_done_c2", 32'(done), 32'd0);
      chk("zl_busy_c2", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      chk("zl_sclk", 32'(m_sclk_tot - t_sclk), 32'd0);
      chk("zl_cmds", 32'(m_cmds - t_cmd), 32'd0);

      // reset in the middle of the address phase
      @(negedge clock);
      start_addr = 24'h111111; length = 16'd5; start = 1'b1;
      for (int rel = 1; rel <= 11; rel++) begin
         @(negedge clock);
         if (rel == 1) start = 1'b0;
         if (rel == 10) reset_n = 1'b0;
         #1;
         if (rel == 10) begin
            chk("mr_busy_before", 32'(busy), 32'd1);
            chk("mr_cs_before",   32'(sram_cs), 32'd0);
         end
         if (rel == 11) begin
            chk("mr_cs",    32'(sram_cs), 32'd1);
            chk("mr_oe",    32'(sram_sio_oe), 32'd0);
            chk("mr_busy",  32'(busy), 32'd0);
            chk("mr_valid", 32'(data_valid), 32'd0);
            chk("mr_sclk",  32'(sram_clock), 32'd0);
            chk("mr_tdo",   32'(sram_sio_tdo), 32'd0);
            reset_n = 1'b1;
         end
      end
      run_xfer(tbl[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
